coffee_order_scheduler: RTL

//  Sits in front of the coffee brewing FSM. Collects orders from N_REQ panels through a

---
 rtl/coffee_order_scheduler_if.sv | 44 ++++
 rtl/coffee_order_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/coffee_order_scheduler_if.sv
// coffee_order_scheduler_if: panel, brew-FSM and status signals of the order scheduler; STATS_EN adds the per-type completion counters
interface coffee_order_scheduler_if #(
    parameter int N_REQ  = 2,
    parameter int QDEPTH = 4
);
    logic [N_REQ-1:0]         req_valid;
    logic [2*N_REQ-1:0]       req_sel;
    logic [N_REQ-1:0]         req_ready;
    logic                     brew_start;
    logic [1:0]               brew_sel;
    logic                     brew_rst;
    logic [2:0]               brew_state;
    logic                     brew_done;
    logic                     cmp_valid;
    logic [$clog2(N_REQ)-1:0] cmp_id;
    logic [1:0]               cmp_sel;
    logic                     illegal;
    logic                     timeout_err;
    logic [$clog2(QDEPTH):0]  q_count;
    logic                     busy;
`ifdef STATS_EN
    logic [15:0]              cnt_e;
    logic [15:0]              cnt_l;
    logic [15:0]              cnt_c;
`endif

    modport slave (
        input  req_valid, req_sel, brew_state, brew_done,
        output req_ready, brew_start, brew_sel, brew_rst, cmp_valid, cmp_id, cmp_sel,
               illegal, timeout_err, q_count, busy
`ifdef STATS_EN
      , output cnt_e, cnt_l, cnt_c
`endif
    );

    modport master (
        output req_valid, req_sel, brew_state, brew_done,
        input  req_ready, brew_start, brew_sel, brew_rst, cmp_valid, cmp_id, cmp_sel,
               illegal, timeout_err, q_count, busy
`ifdef STATS_EN
      , input  cnt_e, cnt_l, cnt_c
`endif
    );
endinterface

// File: rtl/coffee_order_scheduler.sv
// coffee_order_scheduler: round-robin order intake, order FIFO, one-at-a-time brew launch with timeout abort; STATS_EN adds completion counters
module coffee_order_scheduler #(
    parameter int          N_REQ       = 2,
    parameter int          QDEPTH      = 4,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    coffee_order_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IW+1:0]   mem_q [QDEPTH];
    logic [QW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_q, cand, gnt_idx;
    logic [IW-1:0]   cur_id_q, cur_id_d, cmp_id_q, cmp_id_d;
    logic [1:0]      gnt_sel, cur_sel_q, cur_sel_d, cmp_sel_q, cmp_sel_d;
    logic [31:0]     tmr_q, tmr_d;
    logic            gnt_found, grant, push, pop;
    logic            start_q, start_d, brst_q, brst_d, cmp_v_q, cmp_v_d, ill_q, terr_q, terr_d;

    // first valid panel searching upward from the one after the last grant
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(rr_q) + k) % N_REQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign grant         = gnt_found && (cnt_q != CW'(QDEPTH));
    assign gnt_sel       = bus.req_sel[{gnt_idx, 1'b0} +: 2];
    assign push          = grant && (gnt_sel != 2'b11);
    assign cnt_d         = cnt_q + CW'(push) - CW'(pop);
    assign bus.req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

    // FIFO storage; entries carry no reset since occupancy is tracked by cnt_q
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {gnt_idx, gnt_sel};
    end

    // arbiter pointer, FIFO pointers/occupancy and the illegal-order pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ill_q <= 1'b0;
        end else begin
            if (grant) rr_q <= gnt_idx;
            if (push) wr_q <= wr_q + QW'(1);
            if (pop) rd_q <= rd_q + QW'(1);
            cnt_q <= cnt_d;
            ill_q <= grant && (gnt_sel == 2'b11);
        end
    end

    // scheduler state and its registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            start_q   <= 1'b0;
            brst_q    <= 1'b0;
            cmp_v_q   <= 1'b0;
            cmp_id_q  <= '0;
            cmp_sel_q <= '0;
            cur_id_q  <= '0;
            cur_sel_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            start_q   <= start_d;
            brst_q    <= brst_d;
            cmp_v_q   <= cmp_v_d;
            cmp_id_q  <= cmp_id_d;
            cmp_sel_q <= cmp_sel_d;
            cur_id_q  <= cur_id_d;
            cur_sel_q <= cur_sel_d;
            terr_q    <= terr_d;
        end
    end

    // launch when the brew FSM is idle, wait for done or timeout, then wait for it to return to IDLE
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        tmr_d     = tmr_q;
        start_d   = 1'b0;
        brst_d    = 1'b0;
        cmp_v_d   = 1'b0;
        cmp_id_d  = cmp_id_q;
        cmp_sel_d = cmp_sel_q;
        cur_id_d  = cur_id_q;
        cur_sel_d = cur_sel_q;
        terr_d    = terr_q;
        case (state_q)
            S_IDLE: if (cnt_q != '0 && bus.brew_state == 3'd0) begin
                pop                  = 1'b1;
                {cur_id_d, cur_sel_d} = mem_q[rd_q];
                start_d              = 1'b1;
                state_d              = S_START;
            end
            S_START: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmr_d = (&tmr_q) ? tmr_q : tmr_q + 32'd1;
                if (bus.brew_done) begin
                    cmp_v_d   = 1'b1;
                    cmp_id_d  = cur_id_q;
                    cmp_sel_d = cur_sel_q;
                    state_d   = S_DRAIN;
                end else if (tmr_q == TIMEOUT_CYC - 32'd1) begin
                    brst_d  = 1'b1;
                    terr_d  = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            default: if (!bus.brew_done && bus.brew_state == 3'd0) state_d = S_IDLE;
        endcase
    end

    assign bus.brew_start  = start_q;
    assign bus.brew_sel    = cur_sel_q;
    assign bus.brew_rst    = brst_q;
    assign bus.cmp_valid   = cmp_v_q;
    assign bus.cmp_id      = cmp_id_q;
    assign bus.cmp_sel     = cmp_sel_q;
    assign bus.illegal     = ill_q;
    assign bus.timeout_err = terr_q;
    assign bus.q_count     = cnt_q;
    assign bus.busy        = state_q != S_IDLE;

`ifdef STATS_EN
    logic [15:0] cnt_e_q, cnt_l_q, cnt_c_q;

    // per-type completion counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_e_q <= '0;
            cnt_l_q <= '0;
            cnt_c_q <= '0;
        end else if (cmp_v_q) begin
            cnt_e_q <= cnt_e_q + 16'(cmp_sel_q == 2'b00);
            cnt_l_q <= cnt_l_q + 16'(cmp_sel_q == 2'b01);
            cnt_c_q <= cnt_c_q + 16'(cmp_sel_q == 2'b10);
        end
    end

    assign bus.cnt_e = cnt_e_q;
    assign bus.cnt_l = cnt_l_q;
    assign bus.cnt_c = cnt_c_q;
`endif
endmodule
